// File: rtl/iir_biquad_cascade.sv
// Multi-channel cascaded Direct Form I biquad filter sharing one time-multiplexed MAC.
// Coefficients live in a small runtime-writable register file and default to passthrough.
module iir_biquad_cascade #(
  parameter int DATA_W   = 16,
  parameter int COEF_W   = 18,
  parameter int FRAC     = 16,
  parameter int SECTIONS = 4,
  parameter int CHANNELS = 2,
  parameter int ACC_W    = 48
) (
  input  logic                           clk,
  input  logic                           i_rst_n,
  input  logic                           lrclk_posedge,
  input  logic                           i_valid,
  input  logic [CHANNELS*DATA_W-1:0]     x_in,
  input  logic                           i_coef_we,
  input  logic [$clog2(SECTIONS*5)-1:0]  i_coef_addr,
  input  logic [COEF_W-1:0]              i_coef_data,
  output logic [CHANNELS*DATA_W-1:0]     audio_out,
  output logic                           o_valid,
  output logic                           o_busy,
  output logic                           o_overrun,
  output logic [2:0]                     fsm_state
);

  localparam int ADDR_W = $clog2(SECTIONS*5);
  localparam int NCOEF  = SECTIONS*5;
  localparam int CH_W   = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int SEC_W  = (SECTIONS > 1) ? $clog2(SECTIONS) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam logic [CH_W-1:0]         CH_LAST  = CH_W'(CHANNELS-1);
  localparam logic [SEC_W-1:0]        SEC_LAST = SEC_W'(SECTIONS-1);
  localparam logic signed [ACC_W-1:0] SAT_MAX  = ACC_W'((2**(DATA_W-1))-1);
  localparam logic signed [ACC_W-1:0] SAT_MIN  = ~SAT_MAX;

  // Handshake: lrclk_posedge is a one-cycle request accepted in IDLE or OUT (the
  // o_valid cycle); o_valid is a one-cycle pulse with audio_out stable from then on.
  typedef enum logic [2:0] {IDLE, LOAD, MAC, WB, OUT} state_t;

  state_t                     state;
  logic [CH_W-1:0]            ch_idx;
  logic [SEC_W-1:0]           sec_idx;
  logic [2:0]                 k_cnt;
  logic [CHANNELS*DATA_W-1:0] x_lat;
  logic [CHANNELS*DATA_W-1:0] res_q;
  logic [CHANNELS*DATA_W-1:0] out_next;
  logic signed [DATA_W-1:0]   cur_x;
  logic signed [ACC_W-1:0]    acc;

  logic signed [COEF_W-1:0]   coef [NCOEF];
  logic signed [DATA_W-1:0]   x1_h [CHANNELS][SECTIONS];
  logic signed [DATA_W-1:0]   x2_h [CHANNELS][SECTIONS];
  logic signed [DATA_W-1:0]   y1_h [CHANNELS][SECTIONS];
  logic signed [DATA_W-1:0]   y2_h [CHANNELS][SECTIONS];

  logic [ADDR_W-1:0]          c_idx;
  logic signed [COEF_W-1:0]   c_sel;
  logic signed [DATA_W-1:0]   d_sel;
  logic signed [PROD_W-1:0]   c_ext;
  logic signed [PROD_W-1:0]   d_ext;
  logic signed [PROD_W-1:0]   prod;
  logic signed [ACC_W-1:0]    shifted;
  logic signed [DATA_W-1:0]   y_sat;
  logic                       strobe_ok;

  assign fsm_state = state;
  assign strobe_ok = (state == IDLE) || (state == OUT);
  assign c_idx     = ADDR_W'(32'(sec_idx) * 5 + 32'(k_cnt));

  always_comb begin
    c_sel = coef[c_idx];
    case (k_cnt)
      3'd0:    d_sel = cur_x;
      3'd1:    d_sel = x1_h[ch_idx][sec_idx];
      3'd2:    d_sel = x2_h[ch_idx][sec_idx];
      3'd3:    d_sel = y1_h[ch_idx][sec_idx];
      default: d_sel = y2_h[ch_idx][sec_idx];
    endcase
  end

  assign c_ext   = PROD_W'(c_sel);
  assign d_ext   = PROD_W'(d_sel);
  assign prod    = c_ext * d_ext;
  assign shifted = acc >>> FRAC;

  always_comb begin
    if (shifted > SAT_MAX)      y_sat = SAT_MAX[DATA_W-1:0];
    else if (shifted < SAT_MIN) y_sat = SAT_MIN[DATA_W-1:0];
    else                        y_sat = shifted[DATA_W-1:0];
  end

  always_comb begin
    out_next = res_q;
    out_next[32'(ch_idx)*DATA_W +: DATA_W] = y_sat;
  end

  // Coefficients survive flushes; they only change while the datapath is idle.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NCOEF; i++)
        coef[i] <= (i % 5 == 0) ? COEF_W'(1 << FRAC) : '0;
    end else if (i_coef_we && state == IDLE && !o_busy && (32'(i_coef_addr) < NCOEF)) begin
      coef[i_coef_addr] <= i_coef_data;
    end
  end

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state     <= IDLE;
      ch_idx    <= '0;
      sec_idx   <= '0;
      k_cnt     <= '0;
      x_lat     <= '0;
      res_q     <= '0;
      cur_x     <= '0;
      acc       <= '0;
      audio_out <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < SECTIONS; s++) begin
          x1_h[c][s] <= '0;
          x2_h[c][s] <= '0;
          y1_h[c][s] <= '0;
          y2_h[c][s] <= '0;
        end
    end else if (!i_valid) begin
      state     <= IDLE;
      ch_idx    <= '0;
      sec_idx   <= '0;
      k_cnt     <= '0;
      res_q     <= '0;
      acc       <= '0;
      audio_out <= '0;
      o_valid   <= 1'b0;
      o_busy    <= 1'b0;
      o_overrun <= 1'b0;
      for (int c = 0; c < CHANNELS; c++)
        for (int s = 0; s < SECTIONS; s++) begin
          x1_h[c][s] <= '0;
          x2_h[c][s] <= '0;
          y1_h[c][s] <= '0;
          y2_h[c][s] <= '0;
        end
    end else begin
      o_valid <= 1'b0;
      if (lrclk_posedge && !strobe_ok)
        o_overrun <= 1'b1;
      case (state)
        IDLE, OUT: begin
          if (lrclk_posedge) begin
            state  <= LOAD;
            o_busy <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        LOAD: begin
          x_lat   <= x_in;
          cur_x   <= x_in[DATA_W-1:0];
          ch_idx  <= '0;
          sec_idx <= '0;
          k_cnt   <= '0;
          state   <= MAC;
        end
        MAC: begin
          acc <= (k_cnt == 3'd0) ? ACC_W'(prod) : acc + ACC_W'(prod);
          if (k_cnt == 3'd4) state <= WB;
          else               k_cnt <= k_cnt + 3'd1;
        end
        WB: begin
          x2_h[ch_idx][sec_idx] <= x1_h[ch_idx][sec_idx];
          x1_h[ch_idx][sec_idx] <= cur_x;
          y2_h[ch_idx][sec_idx] <= y1_h[ch_idx][sec_idx];
          y1_h[ch_idx][sec_idx] <= y_sat;
          k_cnt <= '0;
          if (sec_idx == SEC_LAST) begin
            res_q   <= out_next;
            sec_idx <= '0;
            if (ch_idx == CH_LAST) begin
              audio_out <= out_next;
              o_valid   <= 1'b1;
              o_busy    <= 1'b0;
              state     <= OUT;
            end else begin
              ch_idx <= ch_idx + 1'b1;
              cur_x  <= x_lat[(32'(ch_idx)+1)*DATA_W +: DATA_W];
              state  <= MAC;
            end
          end else begin
            // Section output feeds the next section of the same channel.
            sec_idx <= sec_idx + 1'b1;
            cur_x   <= y_sat;
            state   <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_cascade.sv
// Bench for iir_biquad_cascade: directed vector tables, hand-written corner sequences,
// and randomized samples/coefficients checked against an integer reference model.
module tb_iir_biquad_cascade;

  localparam int DW  = 16;
  localparam int CW  = 18;
  localparam int CH  = 2;
  localparam int SEC = 4;
  localparam int LAT = 2 + 6*SEC*CH;

  logic            clk;
  logic            rst_n;
  logic            lrclk;
  logic            valid_in;
  logic [CH*DW-1:0] x_in;
  logic            coef_we;
  logic [4:0]      coef_addr;
  logic [CW-1:0]   coef_data;
  logic [CH*DW-1:0] audio_out;
  logic            o_valid;
  logic            o_busy;
  logic            o_overrun;
  logic [2:0]      fsm_state;

  iir_biquad_cascade dut (
    .clk(clk), .i_rst_n(rst_n), .lrclk_posedge(lrclk), .i_valid(valid_in),
    .x_in(x_in), .i_coef_we(coef_we), .i_coef_addr(coef_addr), .i_coef_data(coef_data),
    .audio_out(audio_out), .o_valid(o_valid), .o_busy(o_busy), .o_overrun(o_overrun),
    .fsm_state(fsm_state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [DW-1:0] exp_q[$];

  typedef struct { int x0; int x1; int e0; int e1; } vec_t;
  vec_t imp_tbl[5];
  vec_t sat_tbl[3];

  // Reference model state
  int coef_m[SEC*5];
  int hx1[CH][SEC];
  int hx2[CH][SEC];
  int hy1[CH][SEC];
  int hy2[CH][SEC];
  int m_out[CH];

  function automatic longint sat16(longint v);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic void model_clear();
    for (int c = 0; c < CH; c++)
      for (int s = 0; s < SEC; s++) begin
        hx1[c][s] = 0; hx2[c][s] = 0; hy1[c][s] = 0; hy2[c][s] = 0;
      end
  endfunction

  function automatic void model_step(int xa, int xb);
    int xs[CH];
    xs[0] = xa;
    xs[1] = xb;
    for (int c = 0; c < CH; c++) begin
      longint v = xs[c];
      for (int s = 0; s < SEC; s++) begin
        longint acc = longint'(coef_m[s*5])   * v
                    + longint'(coef_m[s*5+1]) * hx1[c][s]
                    + longint'(coef_m[s*5+2]) * hx2[c][s]
                    + longint'(coef_m[s*5+3]) * hy1[c][s]
                    + longint'(coef_m[s*5+4]) * hy2[c][s];
        longint y = sat16(acc >>> 16);
        hx2[c][s] = hx1[c][s];
        hx1[c][s] = int'(v);
        hy2[c][s] = hy1[c][s];
        hy1[c][s] = int'(y);
        v = y;
      end
      m_out[c] = int'(v);
    end
  endfunction

  function automatic logic [CH*DW-1:0] pack2(int a, int b);
    return {16'(b), 16'(a)};
  endfunction

  function automatic int chan_out(int c);
    logic signed [DW-1:0] v;
    v = audio_out[c*DW +: DW];
    return int'(v);
  endfunction

  // Scoreboard compare
  task automatic check(input string name, input longint act, input longint expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  // Driver tasks; all start and end just after a falling edge.
  task automatic write_coef(input int addr, input int data);
    coef_we   = 1'b1;
    coef_addr = 5'(addr);
    coef_data = CW'(data);
    @(negedge clk);
    coef_we = 1'b0;
    if (addr < SEC*5) coef_m[addr] = data;
  endtask

  task automatic flush();
    valid_in = 1'b0;
    @(negedge clk);
    valid_in = 1'b1;
    model_clear();
    @(negedge clk);
  endtask

  task automatic strobe_cycle(input logic [CH*DW-1:0] xv);
    x_in  = xv;
    lrclk = 1'b1;
    @(negedge clk);
    lrclk = 1'b0;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_valid && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  // Apply one sample; expectations come from the table (use_model=0) or the model.
  task automatic do_sample(input string tag, input int xa, input int xb,
                           input int ea, input int eb, input bit use_model);
    int lat;
    strobe_cycle(pack2(xa, xb));
    wait_valid(lat);
    check({tag, "_latency"}, lat, LAT);
    model_step(xa, xb);
    if (use_model) begin
      ea = m_out[0];
      eb = m_out[1];
    end
    exp_q.push_back(DW'(ea));
    exp_q.push_back(DW'(eb));
    check({tag, "_ch0"}, chan_out(0), longint'($signed(exp_q.pop_front())));
    check({tag, "_ch1"}, chan_out(1), longint'($signed(exp_q.pop_front())));
  endtask

  initial begin
    int lat;
    int pulses;
    int first_pulse;

    imp_tbl[0] = '{1000, 0, 1000, 0};
    imp_tbl[1] = '{0, 0, 500, 0};
    imp_tbl[2] = '{0, 0, 250, 0};
    imp_tbl[3] = '{0, 0, 125, 0};
    imp_tbl[4] = '{0, 0, 62, 0};
    sat_tbl[0] = '{20000, 0, 32767, 0};
    sat_tbl[1] = '{-20000, 0, -32768, 0};
    sat_tbl[2] = '{100, 0, 199, 0};

    for (int i = 0; i < SEC*5; i++) coef_m[i] = (i % 5 == 0) ? 65536 : 0;
    model_clear();

    rst_n = 1'b0; lrclk = 1'b0; valid_in = 1'b1; x_in = '0;
    coef_we = 1'b0; coef_addr = '0; coef_data = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("reset_audio_out", audio_out, 0);
    check("reset_valid", o_valid, 0);
    check("reset_busy", o_busy, 0);
    check("reset_overrun", o_overrun, 0);
    check("reset_state", fsm_state, 0);

    // Passthrough defaults
    do_sample("pass", 1000, -1234, 1000, -1234, 1'b0);
    check("pass_overrun", o_overrun, 0);

    // First-order recursion in section 0 (a1 = +0.5)
    flush();
    write_coef(3, 32768);
    for (int i = 0; i < 5; i++) begin
      do_sample($sformatf("imp%0d", i), imp_tbl[i].x0, imp_tbl[i].x1,
                imp_tbl[i].e0, imp_tbl[i].e1, 1'b0);
      repeat (13) @(negedge clk);
    end

    // Gain saturation and truncation
    flush();
    write_coef(3, 0);
    write_coef(0, 131071);
    for (int i = 0; i < 3; i++)
      do_sample($sformatf("sat%0d", i), sat_tbl[i].x0, sat_tbl[i].x1,
                sat_tbl[i].e0, sat_tbl[i].e1, 1'b0);

    // Cascade order: 0.5 then ~2.0, and reversed
    flush();
    write_coef(0, 32768);
    write_coef(5, 131071);
    do_sample("casc_fwd", 30000, -30000, 29999, -30000, 1'b0);
    flush();
    write_coef(0, 131071);
    write_coef(5, 32768);
    do_sample("casc_rev", 30000, -30000, 16383, -16384, 1'b0);

    // Overrun: second strobe and a coefficient write while busy are both ignored
    flush();
    write_coef(0, 65536);
    write_coef(5, 65536);
    strobe_cycle(pack2(500, -700));
    lat = 1;
    while (lat < 10) begin @(negedge clk); lat++; end
    lrclk = 1'b1; coef_we = 1'b1; coef_addr = 5'd0; coef_data = '0;
    x_in = pack2(7777, 7777);
    @(negedge clk); lat++;
    lrclk = 1'b0; coef_we = 1'b0;
    pulses = 0; first_pulse = 0;
    while (lat < 120) begin
      if (o_valid) begin
        pulses++;
        if (first_pulse == 0) begin
          first_pulse = lat;
          check("ovr_ch0", chan_out(0), 500);
          check("ovr_ch1", chan_out(1), -700);
        end
      end
      @(negedge clk); lat++;
    end
    check("ovr_pulses", pulses, 1);
    check("ovr_latency", first_pulse, LAT);
    check("ovr_flag", o_overrun, 1);
    model_step(500, -700);
    do_sample("ovr_coef_kept", 300, 300, 300, 300, 1'b0);
    check("ovr_sticky", o_overrun, 1);
    flush();
    check("ovr_cleared", o_overrun, 0);

    // Flush in the middle of processing clears history
    write_coef(3, 32768);
    flush();
    do_sample("pre_flush", 1000, 0, 1000, 0, 1'b0);
    @(negedge clk);
    strobe_cycle(pack2(1000, 0));
    repeat (19) @(negedge clk);
    valid_in = 1'b0;
    @(negedge clk);
    check("flush_busy", o_busy, 0);
    check("flush_valid", o_valid, 0);
    check("flush_audio", audio_out, 0);
    check("flush_state", fsm_state, 0);
    valid_in = 1'b1;
    model_clear();
    @(negedge clk);
    do_sample("post_flush", 1000, 0, 1000, 0, 1'b0);

    // Randomized coefficients (including out-of-range addresses) and back-to-back samples
    flush();
    for (int r = 0; r < 4; r++) begin
      @(negedge clk);
      for (int w = 0; w < 4; w++)
        write_coef(int'($urandom_range(0, 31)), int'($urandom_range(0, 262143)) - 131072);
      for (int i = 0; i < 6; i++)
        do_sample($sformatf("rnd%0d_%0d", r, i),
                  int'($urandom_range(0, 65535)) - 32768,
                  int'($urandom_range(0, 65535)) - 32768, 0, 0, 1'b1);
    end
    check("chain_overrun", o_overrun, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
